sobel_window_gen: RTL and testbench

Builds the 3×3 pixel window that the vertical and horizontal Sobel gradient stages consume. Accepts a raster-order 8-bit grayscale pixel stream, stores the two previous image lines in circular line buffers, and presents a packed 72-bit window plus a one-cycle valid strobe for every interior pixel position. Sits directly upstream of the gradient stages; its `V` output connects unchanged to their window input.

---
 rtl/sobel_window_gen_pkg.sv | 25 ++
 rtl/sobel_window_gen_line_buffer.sv | 26 ++
 rtl/sobel_window_gen.sv | 124 ++++++++++++
 tb/tb_sobel_window_gen.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_window_gen_pkg.sv
// Shared definitions for the Sobel window generator and the gradient stages
// that consume its packed 3x3 window.
package sobel_window_gen_pkg;

    localparam int PIX_W     = 8;
    localparam int WIN_SLOTS = 9;

    // Window slot indices, row-major, top-left first.
    localparam int TL = 0;
    localparam int TM = 1;
    localparam int TR = 2;
    localparam int ML = 3;
    localparam int MM = 4;
    localparam int MR = 5;
    localparam int BL = 6;
    localparam int BM = 7;
    localparam int BR = 8;

    // LSB position of a slot inside the packed window; slot TL lands in the
    // MSBs and slot BR (the newest pixel) in the LSBs.
    function automatic int win_pos(input int slot, input int pix_w = PIX_W);
        return (WIN_SLOTS - 1 - slot) * pix_w;
    endfunction

endpackage

// File: rtl/sobel_window_gen_line_buffer.sv
// One image line of pixel storage. Reads are asynchronous, so the data at
// addr is the value stored before any write on the coming clock edge
// (read-before-write at the same address).
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign dout = mem[addr];

    // Store the incoming pixel at the current column.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= din;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Builds the 3x3 pixel window for the Sobel gradient stages from a
// raster-order pixel stream, using two line buffers and a 3x3 shift register.
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PIX_W-1:0]              pix_in,
    input  logic                          pix_valid,
    input  logic                          sof,
    output logic [9*PIX_W-1:0]            V,
    output logic                          win_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col
);
    import sobel_window_gen_pkg::*;

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    logic [COL_W-1:0] col, cur_col, nxt_col;
    logic [ROW_W-1:0] row, cur_row, nxt_row;
    logic [PIX_W-1:0] lb0_dout, lb1_dout;

    // Shift register indexed [row][col]; row 0 is the oldest line, col 2 newest.
    logic [PIX_W-1:0] sr_p0 [3][3];
    logic             vld_p0;
    logic [ROW_W-1:0] crow_p0;
    logic [COL_W-1:0] ccol_p0;
    logic [9*PIX_W-1:0] win_packed;

    // Position of the pixel being accepted (sof forces 0,0) and the next one.
    always_comb begin
        cur_col = sof ? '0 : col;
        cur_row = sof ? '0 : row;
        nxt_col = cur_col + COL_W'(1);
        nxt_row = cur_row;
        if (cur_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + ROW_W'(1);
        end
    end

    // Buffer 0 holds the line two above, fed from buffer 1's outgoing pixel.
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
        .clk   (clk),
        .addr  (cur_col),
        .wr_en (pix_valid),
        .din   (lb1_dout),
        .dout  (lb0_dout)
    );

    // Buffer 1 holds the line directly above.
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk   (clk),
        .addr  (cur_col),
        .wr_en (pix_valid),
        .din   (pix_in),
        .dout  (lb1_dout)
    );

    // Stage p0: advance counters, shift in the new column, flag interior pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            vld_p0  <= 1'b0;
            crow_p0 <= '0;
            ccol_p0 <= '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    sr_p0[r][c] <= '0;
                end
            end
        end else if (pix_valid) begin
            col <= nxt_col;
            row <= nxt_row;
            for (int r = 0; r < 3; r++) begin
                sr_p0[r][0] <= sr_p0[r][1];
                sr_p0[r][1] <= sr_p0[r][2];
            end
            sr_p0[0][2] <= lb0_dout;
            sr_p0[1][2] <= lb1_dout;
            sr_p0[2][2] <= pix_in;
            vld_p0  <= (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));
            crow_p0 <= cur_row - ROW_W'(1);
            ccol_p0 <= cur_col - COL_W'(1);
        end else begin
            vld_p0 <= 1'b0;
        end
    end

    // Pack the shift register into slot order, top-left in the MSBs.
    always_comb begin
        win_packed = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_packed[win_pos(TL + r * 3 + c, PIX_W) +: PIX_W] = sr_p0[r][c];
            end
        end
    end

    // Stage p1: register the window; V only changes when a new window is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            V         <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= vld_p0;
            if (vld_p0) begin
                V       <= win_packed;
                win_row <= crow_p0;
                win_col <= ccol_p0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: a 5x5 instance driven through directed and
// randomized frames against a frame-array reference, plus a minimal 3x3 instance.
module tb_sobel_window_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        sof;
    logic [71:0] V;
    logic        win_valid;
    logic [2:0]  win_row;
    logic [2:0]  win_col;

    logic [7:0]  b_pix_in;
    logic        b_pix_valid;
    logic        b_sof;
    logic [71:0] b_V;
    logic        b_win_valid;
    logic [1:0]  b_win_row;
    logic [1:0]  b_win_col;

    always #5 clk = ~clk;

    sobel_window_gen #(.IMG_WIDTH(5), .IMG_HEIGHT(5), .PIX_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .V         (V),
        .win_valid (win_valid),
        .win_row   (win_row),
        .win_col   (win_col)
    );

    sobel_window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PIX_W(8)) dut_min (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (b_pix_in),
        .pix_valid (b_pix_valid),
        .sof       (b_sof),
        .V         (b_V),
        .win_valid (b_win_valid),
        .win_row   (b_win_row),
        .win_col   (b_win_col)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  frame [5][5];
    int          mrow, mcol;
    bit          exp_vld;
    logic [71:0] exp_v, last_v;
    int          exp_r, exp_c;
    int          win_seen;
    logic [71:0] obs_q [$];

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock of the 5x5 instance: drive, let the edge happen, update the
    // reference, then check the window that was due from the previous accept.
    task automatic cycle(input bit v, input logic [7:0] p, input bit s);
        bit          nv;
        logic [71:0] nwin;
        int          nr, nc;
        pix_valid = v;
        pix_in    = p;
        sof       = s;
        @(posedge clk);
        nv = 1'b0; nwin = '0; nr = 0; nc = 0;
        if (v) begin
            if (s) begin
                mrow = 0;
                mcol = 0;
            end
            frame[mrow][mcol] = p;
            if (mrow >= 2 && mcol >= 2) begin
                nv = 1'b1;
                nr = mrow - 1;
                nc = mcol - 1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        nwin = {nwin[63:0], frame[mrow-2+i][mcol-2+j]};
            end
            mcol++;
            if (mcol == 5) begin
                mcol = 0;
                mrow++;
                if (mrow == 5) mrow = 0;
            end
        end
        #1;
        if (exp_vld) last_v = exp_v;
        chk("win_valid", 72'(win_valid), 72'(exp_vld));
        chk("V", V, last_v);
        if (exp_vld) begin
            chk("win_row", 72'(win_row), 72'(exp_r));
            chk("win_col", 72'(win_col), 72'(exp_c));
        end
        if (win_valid === 1'b1) begin
            win_seen++;
            obs_q.push_back(V);
        end
        exp_vld = nv;
        exp_v   = nwin;
        exp_r   = nr;
        exp_c   = nc;
    endtask

    // mode 0: continuous; 1: three idle cycles after every 2nd pixel;
    // 2: random pixels with random idle gaps.
    task automatic send_frame(input int base, input int mode, input bit with_sof);
        int n = 0;
        logic [7:0] p;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                p = (mode == 2) ? 8'($urandom) : 8'(base + r * 16 + c);
                cycle(1'b1, p, with_sof && r == 0 && c == 0);
                n++;
                if (mode == 1 && (n % 2) == 0) repeat (3) cycle(1'b0, 8'($urandom), 1'b0);
                if (mode == 2 && $urandom_range(0, 2) == 0)
                    repeat ($urandom_range(1, 3)) cycle(1'b0, 8'($urandom), 1'b0);
            end
        end
    endtask

    task automatic start_count();
        win_seen = 0;
        obs_q.delete();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        pix_valid = 1'b0;
        sof = 1'b0;
        #1;
        chk("rst_V", V, 72'h0);
        chk("rst_win_valid", 72'(win_valid), 72'h0);
        chk("rst_win_row", 72'(win_row), 72'h0);
        chk("rst_win_col", 72'(win_col), 72'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mrow = 0;
        mcol = 0;
        exp_vld = 1'b0;
        last_v = '0;
    endtask

    initial begin
        int bcnt;
        logic [71:0] bwin;
        int brow, bcol;
        rst = 1'b0;
        pix_valid = 1'b0; pix_in = '0; sof = 1'b0;
        b_pix_valid = 1'b0; b_pix_in = '0; b_sof = 1'b0;
        mrow = 0; mcol = 0; exp_vld = 1'b0; exp_v = '0; last_v = '0;
        exp_r = 0; exp_c = 0;
        do_reset();

        // Continuous frame.
        start_count();
        send_frame(0, 0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        chk("cont_count", 72'(win_seen), 72'd9);
        chk("cont_first", obs_q[0], 72'h000102101112202122);
        chk("cont_last", obs_q[8], 72'h222324323334424344);

        // Same frame with idle gaps, counters already wrapped.
        start_count();
        send_frame(0, 1, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        chk("gap_count", 72'(win_seen), 72'd9);
        chk("gap_first", obs_q[0], 72'h000102101112202122);
        chk("gap_last", obs_q[8], 72'h222324323334424344);

        // Two frames back to back without sof.
        start_count();
        send_frame(0, 0, 1'b0);
        send_frame(8'h80, 0, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        chk("b2b_count", 72'(win_seen), 72'd18);
        chk("b2b_f2_first", obs_q[9], 72'h808182909192A0A1A2);

        // Reset after pixel (3,1), then a full frame with no sof.
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'((i / 5) * 16 + (i % 5)), i == 0);
        do_reset();
        start_count();
        send_frame(0, 0, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        chk("rst_count", 72'(win_seen), 72'd9);
        chk("rst_first", obs_q[0], 72'h000102101112202122);

        // Realign with sof while the stream sits at (2,3).
        for (int i = 0; i < 13; i++) cycle(1'b1, 8'($urandom), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        start_count();
        send_frame(8'h40, 0, 1'b1);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        chk("sof_count", 72'(win_seen), 72'd9);
        chk("sof_first", obs_q[0], 72'h404142505152606162);

        // Randomized frames with random gaps.
        start_count();
        send_frame(0, 2, 1'b1);
        send_frame(0, 2, 1'b0);
        send_frame(0, 2, 1'b0);
        repeat (2) cycle(1'b0, 8'h00, 1'b0);
        chk("rand_count", 72'(win_seen), 72'd27);

        // Minimal 3x3 frame on the second instance.
        bcnt = 0; bwin = '0; brow = 0; bcol = 0;
        for (int i = 0; i < 11; i++) begin
            b_pix_valid = (i < 9);
            b_pix_in    = 8'((i / 3) * 16 + (i % 3));
            b_sof       = (i == 0);
            @(posedge clk);
            #1;
            if (b_win_valid === 1'b1) begin
                bcnt++;
                bwin = b_V;
                brow = int'(b_win_row);
                bcol = int'(b_win_col);
            end
        end
        b_pix_valid = 1'b0;
        chk("min_count", 72'(bcnt), 72'd1);
        chk("min_V", bwin, 72'h000102101112202122);
        chk("min_row", 72'(brow), 72'd1);
        chk("min_col", 72'(bcol), 72'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
